// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset pulse, lock debounce and staggered 4-domain reset release.
//   refclk      : free-running reference clock
//   rst         : synchronous active-high reset
//   pll_locked  : PLL lock flag, asynchronous to refclk
//   restart_req : one-cycle request to re-sequence the PLL
//   pll_rst     : PLL reset, active-high
//   dom_rst     : per-domain resets, bit i for PLL output i
//   ready       : all domains released and lock stable
//   lock_lost   : one-cycle pulse when lock drops while running
//   retry_count : saturating count of lock timeouts and lock losses
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 65535,
  parameter int unsigned STAGGER_CYCLES     = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic [3:0] dom_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_count
);
  localparam logic [15:0] RST_LAST = 16'(PLL_RST_CYCLES - 1);
  localparam logic [15:0] STB_LAST = 16'(LOCK_STABLE_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STG_LAST = 16'(STAGGER_CYCLES - 1);
  typedef enum logic [2:0] {PLLRST, WAITLOCK, DEBOUNCE, RELEASE, RUN} state_t;
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [1:0]  idx, idx_n;
  logic [3:0]  dom_rel, dom_n;
  logic        sync1, lock_s, lost_n, retry_inc;
  // RELEASE counts down between releases so the first bit clears on the cycle after entry.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    dom_rel   = dom_rst;
    lost_n    = 1'b0;
    retry_inc = 1'b0;
    if (restart_req) begin
      state_n = PLLRST;
      cnt_n   = '0;
    end else begin
      case (state)
        PLLRST: begin
          state_n = (cnt == RST_LAST) ? WAITLOCK : PLLRST;
          cnt_n   = (cnt == RST_LAST) ? '0 : cnt + 16'd1;
        end
        WAITLOCK: begin
          retry_inc = !lock_s && cnt == TO_LAST;
          state_n   = lock_s ? DEBOUNCE : retry_inc ? PLLRST : WAITLOCK;
          cnt_n     = (lock_s || retry_inc) ? '0 : cnt + 16'd1;
        end
        DEBOUNCE: begin
          state_n = !lock_s ? WAITLOCK : (cnt == STB_LAST) ? RELEASE : DEBOUNCE;
          cnt_n   = (!lock_s || cnt == STB_LAST) ? '0 : cnt + 16'd1;
          idx_n   = '0;
        end
        RELEASE: begin
          if (!lock_s) begin
            state_n   = PLLRST;
            cnt_n     = '0;
            retry_inc = 1'b1;
          end else if (cnt == '0) begin
            dom_rel = dom_rst & ~(4'b1 << idx);
            cnt_n   = STG_LAST;
            state_n = (idx == 2'd3) ? RUN : RELEASE;
            idx_n   = (idx == 2'd3) ? idx : idx + 2'd1;
          end else begin
            cnt_n = cnt - 16'd1;
          end
        end
        RUN: begin
          lost_n    = !lock_s;
          retry_inc = !lock_s;
          state_n   = lock_s ? RUN : PLLRST;
          cnt_n     = lock_s ? cnt : '0;
        end
        default: begin
          state_n = PLLRST;
          cnt_n   = '0;
        end
      endcase
    end
    dom_n = (state_n == RUN) ? 4'h0 : (state_n == RELEASE) ? dom_rel : 4'hF;
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1       <= 1'b0;
      lock_s      <= 1'b0;
      state       <= PLLRST;
      cnt         <= '0;
      idx         <= '0;
      pll_rst     <= 1'b1;
      dom_rst     <= 4'hF;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      sync1       <= pll_locked;
      lock_s      <= sync1;
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      pll_rst     <= state_n == PLLRST;
      dom_rst     <= dom_n;
      ready       <= state_n == RUN;
      lock_lost   <= lost_n;
      retry_count <= (retry_inc && retry_count != 4'hF) ? retry_count + 4'd1 : retry_count;
    end
  end
endmodule
